// File: rtl/ccip_tx_credit_shim.sv
`default_nettype none
// ============================================================================
// Module   : ccip_tx_credit_shim
// Brief    : Per-channel CCI-P Tx request FIFOs with AFU almost-full slack and
//            sticky overflow flags. Optional statistics: CCIP_TX_SHIM_STATS_EN.
// Revision : 1.0  initial release
// ============================================================================

module ccip_tx_credit_shim_chan #(
   parameter int W             = 74,
   parameter int DEPTH         = 64,
   parameter int ALMFULL_SLACK = 8
) (
   input  logic                   pClk,
   input  logic                   SoftReset_n,
   input  logic                   i_pushValid,
   input  logic [W-1:0]           i_pushData,
   input  logic                   i_portAlmFull,
   output logic                   o_popValid,
   output logic [W-1:0]           o_popData,
   output logic                   o_almFull,
   output logic                   o_overflow,
   output logic [31:0]            o_issued,
   output logic [$clog2(DEPTH):0] o_wmark
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam logic [CW-1:0] c_full      = CW'(DEPTH);
   localparam logic [CW-1:0] c_almThresh = CW'(DEPTH - ALMFULL_SLACK);

   logic [W-1:0]  r_mem [DEPTH];
   logic [AW-1:0] r_wrPtr;
   logic [AW-1:0] r_rdPtr;
   logic [CW-1:0] r_count;
   logic          r_almFull;
   logic          r_overflow;

   logic          w_empty;
   logic          w_pop;
   logic          w_pushAcc;
   logic [CW-1:0] w_countNext;

   assign w_empty   = (r_count == '0);
   assign w_pop     = !w_empty && !i_portAlmFull;
   // A push into a full FIFO still lands when the head leaves on the same edge.
   assign w_pushAcc = i_pushValid && ((r_count < c_full) || w_pop);

   always_comb begin
      w_countNext = r_count;
      if (w_pushAcc && !w_pop) begin
         w_countNext = r_count + CW'(1);
      end else if (w_pop && !w_pushAcc) begin
         w_countNext = r_count - CW'(1);
      end
   end

   always_ff @(posedge pClk) begin
      if (w_pushAcc) begin
         r_mem[r_wrPtr] <= i_pushData;
      end
   end

   always_ff @(posedge pClk or negedge SoftReset_n) begin
      if (!SoftReset_n) begin
         r_wrPtr    <= '0;
         r_rdPtr    <= '0;
         r_count    <= '0;
         r_almFull  <= 1'b0;
         r_overflow <= 1'b0;
      end else begin
         if (w_pushAcc) begin
            r_wrPtr <= r_wrPtr + AW'(1);
         end
         if (w_pop) begin
            r_rdPtr <= r_rdPtr + AW'(1);
         end
         r_count   <= w_countNext;
         r_almFull <= (w_countNext >= c_almThresh);
         if (i_pushValid && !w_pushAcc) begin
            r_overflow <= 1'b1;
         end
      end
   end

   assign o_popValid = w_pop;
   // Gate on empty so unwritten storage never reaches the port.
   assign o_popData  = w_empty ? '0 : r_mem[r_rdPtr];
   assign o_almFull  = r_almFull;
   assign o_overflow = r_overflow;

`ifdef CCIP_TX_SHIM_STATS_EN
   logic [31:0]   r_issued;
   logic [CW-1:0] r_wmark;

   always_ff @(posedge pClk or negedge SoftReset_n) begin
      if (!SoftReset_n) begin
         r_issued <= '0;
         r_wmark  <= '0;
      end else begin
         if (w_pop && (r_issued != 32'hFFFF_FFFF)) begin
            r_issued <= r_issued + 32'd1;
         end
         if (w_countNext > r_wmark) begin
            r_wmark <= w_countNext;
         end
      end
   end

   assign o_issued = r_issued;
   assign o_wmark  = r_wmark;
`else
   assign o_issued = '0;
   assign o_wmark  = '0;
`endif

endmodule

module ccip_tx_credit_shim #(
   parameter int C0_W          = 74,
   parameter int C1_W          = 586,
   parameter int DEPTH         = 64,
   parameter int ALMFULL_SLACK = 8
) (
   input  logic                   pClk,
   input  logic                   SoftReset_n,
   input  logic                   afu_c0_valid,
   input  logic [C0_W-1:0]        afu_c0_data,
   input  logic                   afu_c1_valid,
   input  logic [C1_W-1:0]        afu_c1_data,
   output logic                   afu_c0_almFull,
   output logic                   afu_c1_almFull,
   input  logic                   cp_c0_almFull,
   input  logic                   cp_c1_almFull,
   output logic                   cp_c0_valid,
   output logic [C0_W-1:0]        cp_c0_data,
   output logic                   cp_c1_valid,
   output logic [C1_W-1:0]        cp_c1_data,
   output logic [1:0]             overflow,
   output logic [31:0]            c0_issued,
   output logic [31:0]            c1_issued,
   output logic [$clog2(DEPTH):0] c0_wmark,
   output logic [$clog2(DEPTH):0] c1_wmark
);

   logic w_c0Overflow;
   logic w_c1Overflow;

   ccip_tx_credit_shim_chan #(
      .W             (C0_W),
      .DEPTH         (DEPTH),
      .ALMFULL_SLACK (ALMFULL_SLACK)
   ) u_c0 (
      .pClk          (pClk),
      .SoftReset_n   (SoftReset_n),
      .i_pushValid   (afu_c0_valid),
      .i_pushData    (afu_c0_data),
      .i_portAlmFull (cp_c0_almFull),
      .o_popValid    (cp_c0_valid),
      .o_popData     (cp_c0_data),
      .o_almFull     (afu_c0_almFull),
      .o_overflow    (w_c0Overflow),
      .o_issued      (c0_issued),
      .o_wmark       (c0_wmark)
   );

   ccip_tx_credit_shim_chan #(
      .W             (C1_W),
      .DEPTH         (DEPTH),
      .ALMFULL_SLACK (ALMFULL_SLACK)
   ) u_c1 (
      .pClk          (pClk),
      .SoftReset_n   (SoftReset_n),
      .i_pushValid   (afu_c1_valid),
      .i_pushData    (afu_c1_data),
      .i_portAlmFull (cp_c1_almFull),
      .o_popValid    (cp_c1_valid),
      .o_popData     (cp_c1_data),
      .o_almFull     (afu_c1_almFull),
      .o_overflow    (w_c1Overflow),
      .o_issued      (c1_issued),
      .o_wmark       (c1_wmark)
   );

   assign overflow = {w_c1Overflow, w_c0Overflow};

endmodule
`default_nettype wire

// File: tb/tb_ccip_tx_credit_shim.sv
`default_nettype none
// ============================================================================
// Module   : tb_ccip_tx_credit_shim
// Brief    : Scoreboard bench for ccip_tx_credit_shim (both stats builds).
// Revision : 1.0  initial release
// ============================================================================
module tb_ccip_tx_credit_shim;

   localparam int C0_W          = 74;
   localparam int C1_W          = 586;
   localparam int DEPTH         = 64;
   localparam int ALMFULL_SLACK = 8;
   localparam int WMW           = $clog2(DEPTH) + 1;

   logic            clk = 1'b0;
   logic            rst_n = 1'b0;
   logic            afu_c0_valid, afu_c1_valid;
   logic [C0_W-1:0] afu_c0_data;
   logic [C1_W-1:0] afu_c1_data;
   logic            afu_c0_almFull, afu_c1_almFull;
   logic            cp_c0_almFull, cp_c1_almFull;
   logic            cp_c0_valid, cp_c1_valid;
   logic [C0_W-1:0] cp_c0_data;
   logic [C1_W-1:0] cp_c1_data;
   logic [1:0]      overflow;
   logic [31:0]     c0_issued, c1_issued;
   logic [WMW-1:0]  c0_wmark, c1_wmark;

   always #5 clk = ~clk;

   ccip_tx_credit_shim #(
      .C0_W(C0_W), .C1_W(C1_W), .DEPTH(DEPTH), .ALMFULL_SLACK(ALMFULL_SLACK)
   ) dut (
      .pClk(clk), .SoftReset_n(rst_n),
      .afu_c0_valid(afu_c0_valid), .afu_c0_data(afu_c0_data),
      .afu_c1_valid(afu_c1_valid), .afu_c1_data(afu_c1_data),
      .afu_c0_almFull(afu_c0_almFull), .afu_c1_almFull(afu_c1_almFull),
      .cp_c0_almFull(cp_c0_almFull), .cp_c1_almFull(cp_c1_almFull),
      .cp_c0_valid(cp_c0_valid), .cp_c0_data(cp_c0_data),
      .cp_c1_valid(cp_c1_valid), .cp_c1_data(cp_c1_data),
      .overflow(overflow),
      .c0_issued(c0_issued), .c1_issued(c1_issued),
      .c0_wmark(c0_wmark), .c1_wmark(c1_wmark)
   );

   int nCmp = 0;
   int nErr = 0;

   logic [C1_W-1:0] sb0 [$];
   logic [C1_W-1:0] sb1 [$];
   bit              mAf [2];
   bit              mOvf [2];
   int              mIssued [2];
   int              mWmark [2];

   task automatic checkVal(input string tag, input logic [C1_W-1:0] obs, input logic [C1_W-1:0] exp);
      nCmp++;
      if (obs !== exp) begin
         nErr++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   task automatic modelReset();
      sb0.delete();
      sb1.delete();
      for (int i = 0; i < 2; i++) begin
         mAf[i] = 1'b0; mOvf[i] = 1'b0; mIssued[i] = 0; mWmark[i] = 0;
      end
   endtask

   // One cycle of the reference FIFO for channel ch, evaluated before the edge.
   task automatic modelStep(input int ch, input logic v, input logic [C1_W-1:0] d, input logic pAf,
                            input logic dV, input logic [C1_W-1:0] dD, input logic dAf);
      int              n;
      logic            expV;
      logic [C1_W-1:0] head;
      n    = (ch == 0) ? sb0.size() : sb1.size();
      expV = (n > 0) && !pAf;
      checkVal($sformatf("c%0d_almFull", ch), C1_W'(dAf), C1_W'(mAf[ch]));
      checkVal($sformatf("c%0d_valid", ch), C1_W'(dV), C1_W'(expV));
      if (expV && dV) begin
         if (ch == 0) head = sb0.pop_front();
         else         head = sb1.pop_front();
         checkVal($sformatf("c%0d_data", ch), dD, head);
      end else if (expV) begin
         if (ch == 0) void'(sb0.pop_front());
         else         void'(sb1.pop_front());
      end
      if (expV) mIssued[ch]++;
      if (v && (n < DEPTH || expV)) begin
         if (ch == 0) sb0.push_back(d);
         else         sb1.push_back(d);
      end else if (v) begin
         mOvf[ch] = 1'b1;
      end
      n = (ch == 0) ? sb0.size() : sb1.size();
      mAf[ch] = (n >= DEPTH - ALMFULL_SLACK);
      if (n > mWmark[ch]) mWmark[ch] = n;
   endtask

   always @(negedge clk) begin
      if (!rst_n) begin
         modelReset();
      end else begin
         checkVal("overflow", C1_W'(overflow), C1_W'({mOvf[1], mOvf[0]}));
         modelStep(0, afu_c0_valid, C1_W'(afu_c0_data), cp_c0_almFull, cp_c0_valid, C1_W'(cp_c0_data), afu_c0_almFull);
         modelStep(1, afu_c1_valid, afu_c1_data, cp_c1_almFull, cp_c1_valid, cp_c1_data, afu_c1_almFull);
      end
   end

   function automatic logic [C0_W-1:0] mkC0();
      logic [C0_W-1:0] v = '0;
      for (int i = 0; i < 3; i++) v = (v << 32) | C0_W'($urandom());
      return v;
   endfunction

   function automatic logic [C1_W-1:0] mkC1();
      logic [C1_W-1:0] v = '0;
      for (int i = 0; i < 19; i++) v = (v << 32) | C1_W'($urandom());
      return v;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drainAll();
      int k = 0;
      afu_c0_valid = 1'b0; afu_c1_valid = 1'b0;
      cp_c0_almFull = 1'b0; cp_c1_almFull = 1'b0;
      while ((sb0.size() != 0 || sb1.size() != 0 || cp_c0_valid || cp_c1_valid) && k < 300) begin
         tick();
         k++;
      end
      checkVal("drain_in_budget", C1_W'(k < 300), C1_W'(1));
   endtask

   task automatic checkZeroOutputs(input string tag);
      checkVal({tag, "_c0_valid"}, C1_W'(cp_c0_valid), '0);
      checkVal({tag, "_c1_valid"}, C1_W'(cp_c1_valid), '0);
      checkVal({tag, "_c0_data"}, C1_W'(cp_c0_data), '0);
      checkVal({tag, "_c1_data"}, cp_c1_data, '0);
      checkVal({tag, "_afu_af"}, C1_W'({afu_c1_almFull, afu_c0_almFull}), '0);
      checkVal({tag, "_overflow"}, C1_W'(overflow), '0);
      checkVal({tag, "_stats"}, C1_W'({c1_wmark, c0_wmark, c1_issued, c0_issued}), '0);
   endtask

   initial begin
      afu_c0_valid = 1'b0; afu_c1_valid = 1'b0;
      afu_c0_data = '0; afu_c1_data = '0;
      cp_c0_almFull = 1'b0; cp_c1_almFull = 1'b0;
      repeat (3) tick();
      checkZeroOutputs("reset");
      rst_n = 1'b1;
      tick();

      // Latency and order: payloads 1..20 back-to-back on c0.
      checkVal("lat_pre_valid", C1_W'(cp_c0_valid), '0);
      for (int i = 1; i <= 20; i++) begin
         afu_c0_data  = C0_W'(i);
         afu_c0_valid = 1'b1;
         tick();
         if (i == 1) begin
            checkVal("lat_first_valid", C1_W'(cp_c0_valid), C1_W'(1));
            checkVal("lat_first_data", C1_W'(cp_c0_data), C1_W'(1));
         end
      end
      drainAll();

      // Backpressure: 56 c1 pushes into a blocked port.
      cp_c1_almFull = 1'b1;
      for (int i = 1; i <= 56; i++) begin
         afu_c1_data  = mkC1();
         afu_c1_valid = 1'b1;
         tick();
         checkVal($sformatf("bp_almFull_%0d", i), C1_W'(afu_c1_almFull), C1_W'(i == 56));
      end
      afu_c1_valid  = 1'b0;
      cp_c1_almFull = 1'b0;
      tick();
      checkVal("bp_release_almFull", C1_W'(afu_c1_almFull), '0);
      drainAll();

      // Overflow: fill c0, drop one, then push+pop at full.
      cp_c0_almFull = 1'b1;
      for (int i = 0; i < DEPTH; i++) begin
         afu_c0_data  = mkC0();
         afu_c0_valid = 1'b1;
         tick();
      end
      checkVal("ovf_before", C1_W'(overflow), '0);
      checkVal("ovf_full_af", C1_W'(afu_c0_almFull), C1_W'(1));
      afu_c0_data = mkC0();
      tick();
      checkVal("ovf_set", C1_W'(overflow), C1_W'(2'b01));
      cp_c0_almFull = 1'b0;
      afu_c0_data   = mkC0();
      tick();
      checkVal("ovf_hold", C1_W'(overflow), C1_W'(2'b01));
      checkVal("ovf_pushpop_af", C1_W'(afu_c0_almFull), C1_W'(1));
      drainAll();

      // Independence: c0 blocked, c1 free, interleaved pushes.
      cp_c0_almFull = 1'b1;
      for (int i = 0; i < 30; i++) begin
         afu_c0_valid = (i % 2 == 0);
         afu_c0_data  = mkC0();
         afu_c1_valid = 1'b1;
         afu_c1_data  = mkC1();
         tick();
         checkVal("ind_c1_flow", C1_W'(cp_c1_valid), C1_W'(1));
         checkVal("ind_c0_blocked", C1_W'(cp_c0_valid), '0);
      end
      drainAll();

      // Random traffic with random port backpressure.
      for (int i = 0; i < 300; i++) begin
         afu_c0_valid  = ($urandom_range(0, 3) != 0);
         afu_c1_valid  = ($urandom_range(0, 2) != 0);
         afu_c0_data   = mkC0();
         afu_c1_data   = mkC1();
         cp_c0_almFull = ($urandom_range(0, 3) == 0);
         cp_c1_almFull = ($urandom_range(0, 1) == 0);
         tick();
      end
      drainAll();

`ifdef CCIP_TX_SHIM_STATS_EN
      checkVal("c0_issued", C1_W'(c0_issued), C1_W'(mIssued[0]));
      checkVal("c1_issued", C1_W'(c1_issued), C1_W'(mIssued[1]));
      checkVal("c0_wmark", C1_W'(c0_wmark), C1_W'(mWmark[0]));
      checkVal("c1_wmark", C1_W'(c1_wmark), C1_W'(mWmark[1]));
`else
      checkVal("c0_issued", C1_W'(c0_issued), '0);
      checkVal("c1_issued", C1_W'(c1_issued), '0);
      checkVal("c0_wmark", C1_W'(c0_wmark), '0);
      checkVal("c1_wmark", C1_W'(c1_wmark), '0);
`endif

      // Reset mid-traffic with 10 entries queued per channel.
      cp_c0_almFull = 1'b1; cp_c1_almFull = 1'b1;
      for (int i = 0; i < 10; i++) begin
         afu_c0_valid = 1'b1; afu_c0_data = mkC0();
         afu_c1_valid = 1'b1; afu_c1_data = mkC1();
         tick();
      end
      afu_c0_valid = 1'b0; afu_c1_valid = 1'b0;
      cp_c0_almFull = 1'b0;
      #1;
      checkVal("rst_pre_valid", C1_W'(cp_c0_valid), C1_W'(1));
      rst_n = 1'b0;
      #1;
      checkZeroOutputs("midrst");
      tick();
      tick();
      rst_n = 1'b1;
      cp_c1_almFull = 1'b0;
      for (int i = 0; i < 5; i++) begin
         tick();
         checkVal("post_rst_stale", C1_W'({cp_c1_valid, cp_c0_valid}), '0);
      end
      afu_c0_valid = 1'b1;
      afu_c0_data  = C0_W'(74'h2A5);
      tick();
      afu_c0_valid = 1'b0;
      checkVal("post_rst_push_data", C1_W'(cp_c0_data), C1_W'(74'h2A5));
      drainAll();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nErr);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule
`default_nettype wire
